// File: rtl/instr_rx.sv
// instr_rx: 8N1 UART receiver assembling two bytes (low first) into a 16-bit instruction word
module instr_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx_serial,
  output logic        o_rx_dv,
  output logic [15:0] o_rx_instr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s;
  logic [CW-1:0] clk_cnt, cnt_n;
  logic [2:0] bit_idx, idx_n;
  logic [7:0] rx_byte, byte_n, low_reg, low_n;
  logic byte_ptr, ptr_n, dv_n;
  logic [15:0] instr_n;
  logic half, last;
  assign rx_s = sync[1];
  assign half = clk_cnt == CW'((CLKS_PER_BIT - 1) / 2);
  assign last = clk_cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], i_rx_serial};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      low_reg    <= '0;
      byte_ptr   <= 1'b0;
      o_rx_dv    <= 1'b0;
      o_rx_instr <= '0;
    end else begin
      state      <= state_n;
      clk_cnt    <= cnt_n;
      bit_idx    <= idx_n;
      rx_byte    <= byte_n;
      low_reg    <= low_n;
      byte_ptr   <= ptr_n;
      o_rx_dv    <= dv_n;
      o_rx_instr <= instr_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = clk_cnt + CW'(1);
    idx_n   = bit_idx;
    byte_n  = rx_byte;
    low_n   = low_reg;
    ptr_n   = byte_ptr;
    dv_n    = 1'b0;
    instr_n = o_rx_instr;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : START;
      end
      START:
        if (half) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      DATA:
        if (last) begin
          cnt_n           = '0;
          byte_n[bit_idx] = rx_s;
          idx_n           = bit_idx + 3'd1;
          state_n         = bit_idx == 3'd7 ? STOP : DATA;
        end
      STOP:
        if (last) begin
          cnt_n   = '0;
          state_n = CLEANUP;
          ptr_n   = rx_s & ~byte_ptr;
          low_n   = rx_s & ~byte_ptr ? rx_byte : low_reg;
          dv_n    = rx_s & byte_ptr;
          instr_n = rx_s & byte_ptr ? {rx_byte, low_reg} : o_rx_instr;
        end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_instr_rx.sv
// tb_instr_rx: directed bench for instr_rx driving 8N1 frames on the serial line
`timescale 1ns/1ps
module tb_instr_rx;
  localparam int CPB = 217;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic dv;
  logic [15:0] instr;
  int vecs = 0;
  int errs = 0;
  int bit_ns = 8600;
  longint cyc = 0;
  logic [15:0] cap_w[$];
  longint cap_t[$];
  instr_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .i_rx_serial(rx),
    .o_rx_dv(dv),
    .o_rx_instr(instr)
  );
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (dv) begin
      cap_w.push_back(instr);
      cap_t.push_back(cyc);
    end
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop;
    #(bit_ns);
    rx = 1'b1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vecs++; if (dv !== 1'b0) begin errs++; $display("FAIL reset_dv: got %b want 0", dv); end
    vecs++; if (instr !== 16'h0000) begin errs++; $display("FAIL reset_instr: got %h want 0000", instr); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vecs++; if (dv !== 1'b0) begin errs++; $display("FAIL post_reset_dv: got %b want 0", dv); end
    vecs++; if (instr !== 16'h0000) begin errs++; $display("FAIL post_reset_instr: got %h want 0000", instr); end
  endtask
  task automatic test_basic;
    int n = cap_w.size();
    send_byte(8'h37);
    #(2 * bit_ns);
    vecs++; if (cap_w.size() != n) begin errs++; $display("FAIL basic_low_no_dv: got %0d pulses want 0", cap_w.size() - n); end
    vecs++; if (instr !== 16'h0000) begin errs++; $display("FAIL basic_low_hold: got %h want 0000", instr); end
    send_byte(8'hAB);
    vecs++; if (instr !== 16'hAB37) begin errs++; $display("FAIL basic_instr: got %h want ab37", instr); end
    #(2 * bit_ns);
    vecs++; if (cap_w.size() != n + 1) begin errs++; $display("FAIL basic_pulses: got %0d want 1", cap_w.size() - n); end
    vecs++; if (dv !== 1'b0) begin errs++; $display("FAIL basic_dv_low: got %b want 0", dv); end
  endtask
  task automatic test_order_hold;
    int n = cap_w.size();
    send_byte(8'h00);
    send_byte(8'hFF);
    #(bit_ns);
    vecs++; if (instr !== 16'hFF00) begin errs++; $display("FAIL order_first: got %h want ff00", instr); end
    fork
      send_byte(8'hFF);
      begin
        #(5 * bit_ns);
        vecs++; if (instr !== 16'hFF00) begin errs++; $display("FAIL order_hold: got %h want ff00", instr); end
      end
    join
    send_byte(8'h00);
    #(bit_ns);
    vecs++; if (instr !== 16'h00FF) begin errs++; $display("FAIL order_second: got %h want 00ff", instr); end
    vecs++; if (cap_w.size() != n + 2) begin errs++; $display("FAIL order_pulses: got %0d want 2", cap_w.size() - n); end
  endtask
  task automatic test_false_start;
    int n = cap_w.size();
    rx = 1'b0;
    #2000;
    rx = 1'b1;
    #(2 * bit_ns);
    vecs++; if (cap_w.size() != n) begin errs++; $display("FAIL glitch_no_dv: got %0d want 0", cap_w.size() - n); end
    send_byte(8'h12);
    send_byte(8'h34);
    #(bit_ns);
    vecs++; if (instr !== 16'h3412) begin errs++; $display("FAIL glitch_instr: got %h want 3412", instr); end
    vecs++; if (cap_w.size() != n + 1) begin errs++; $display("FAIL glitch_pulses: got %0d want 1", cap_w.size() - n); end
  endtask
  task automatic test_framing;
    int n = cap_w.size();
    send_byte(8'h55, 1'b0);
    #(2 * bit_ns);
    vecs++; if (cap_w.size() != n) begin errs++; $display("FAIL frame_no_dv: got %0d want 0", cap_w.size() - n); end
    send_byte(8'h11);
    send_byte(8'h22);
    #(bit_ns);
    vecs++; if (instr !== 16'h2211) begin errs++; $display("FAIL frame_instr: got %h want 2211", instr); end
    vecs++; if (cap_w.size() != n + 1) begin errs++; $display("FAIL frame_pulses: got %0d want 1", cap_w.size() - n); end
  endtask
  task automatic test_reset_mid_frame;
    logic [7:0] hb = 8'hAB;
    int n;
    send_byte(8'h37);
    #(bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 4; i++) begin
      rx = hb[i];
      #(bit_ns);
    end
    rx = hb[4];
    #(bit_ns / 2);
    rst = 1'b1;
    #1;
    vecs++; if (instr !== 16'h0000) begin errs++; $display("FAIL midrst_instr: got %h want 0000", instr); end
    vecs++; if (dv !== 1'b0) begin errs++; $display("FAIL midrst_dv: got %b want 0", dv); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #(2 * bit_ns);
    n = cap_w.size();
    send_byte(8'hCD);
    send_byte(8'h01);
    #(bit_ns);
    vecs++; if (instr !== 16'h01CD) begin errs++; $display("FAIL midrst_instr_after: got %h want 01cd", instr); end
    vecs++; if (cap_w.size() != n + 1) begin errs++; $display("FAIL midrst_pulses: got %0d want 1", cap_w.size() - n); end
  endtask
  task automatic test_back_to_back;
    int n = cap_w.size();
    longint gap;
    bit_ns = CPB * 40;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    #(bit_ns);
    vecs++; if (cap_w.size() != n + 2) begin errs++; $display("FAIL b2b_pulses: got %0d want 2", cap_w.size() - n); end
    vecs++; if (instr !== 16'h0403) begin errs++; $display("FAIL b2b_instr: got %h want 0403", instr); end
    if (cap_w.size() >= n + 2) begin
      gap = cap_t[n + 1] - cap_t[n];
      vecs++; if (cap_w[n] !== 16'h0201) begin errs++; $display("FAIL b2b_first: got %h want 0201", cap_w[n]); end
      vecs++; if (gap < CPB * 20 - 2 || gap > CPB * 20 + 2) begin errs++; $display("FAIL b2b_gap: got %0d cycles want %0d", gap, CPB * 20); end
    end
    bit_ns = 8600;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_order_hold;
    test_false_start;
    test_framing;
    test_reset_mid_frame;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/instr_rx.md
# instr_rx

Serial instruction receiver for the FRANK6000 core. It deserializes an 8N1 UART stream on `i_rx_serial` and assembles two consecutive bytes into one 16-bit instruction word. The first byte received is the low byte and the second is the high byte. It sits between the board's UART RX pin and the instruction loader, and presents each completed word with a one-cycle valid strobe.

## Interface
- `CLKS_PER_BIT`, default 217: clock cycles per UART bit (25 MHz / 115200 baud); must be ≥ 4.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `i_rx_serial`  input  1  UART line, idle high, asynchronous to `clk`.
- `o_rx_dv`  output  1  one-cycle pulse when a full 16-bit instruction has been received.
- `o_rx_instr`  output  16  last completed instruction, `{high_byte, low_byte}`; held between completions.

## Operation
- **Input synchronizer**
  - `i_rx_serial` passes through a 2-flop synchronizer, reset to 1.
  - All FSM decisions use the synchronized value `rx_s`.
- **Bit-level FSM** (`clk_cnt` counts cycles within a bit, `bit_idx` 0..7):
  - **IDLE:** `clk_cnt=0`, `bit_idx=0`. On `rx_s==0` go to START.
  - **START:** count to `(CLKS_PER_BIT-1)/2` (integer division; mid start bit).
    - If `rx_s==0` at that point: reset `clk_cnt` and go to DATA.
    - Otherwise it is a false start: go to IDLE with no other state change.
  - **DATA:** every `CLKS_PER_BIT` cycles, sample `rx_s` into `rx_byte[bit_idx]`, LSB first.
    - After bit 7 is sampled, go to STOP.
  - **STOP:** after `CLKS_PER_BIT` cycles, sample `rx_s` (mid stop bit).
    - Sample 1 = valid byte; run the byte handling below.
    - Sample 0 = framing error: discard the byte, clear the byte pointer to "low", no strobe.
    - In either case go to CLEANUP.
  - **CLEANUP:** one cycle, then IDLE. A new start bit is accepted from IDLE only.
- **Byte assembly** (`byte_ptr`, 1 bit, reset 0):
  - Valid byte with `byte_ptr==0`: store it in the internal `low_reg`; set `byte_ptr=1`. No outputs change.
  - Valid byte with `byte_ptr==1`: load `o_rx_instr <= {rx_byte, low_reg}`, pulse `o_rx_dv`, set `byte_ptr=0`.
  - `o_rx_instr` never shows a partially received instruction.
  - There is no inter-byte timeout. A lone low byte waits indefinitely for its high byte.
- **Reset** (asynchronous, any time, including mid-frame):
  - FSM goes to IDLE; counters, `rx_byte`, `low_reg`, `byte_ptr` clear to 0.
  - `o_rx_dv=0`, `o_rx_instr=16'h0000`.
  - A frame interrupted by reset is lost; reception restarts at the next falling edge after reset deasserts.

## Timing
- Line-to-FSM latency: 2 cycles (synchronizer).
- Data bit n is sampled at about `(CLKS_PER_BIT-1)/2 + (n+1)·CLKS_PER_BIT` cycles after the start edge is seen. The stop bit is sampled `CLKS_PER_BIT` cycles after bit 7.
- `o_rx_instr` and `o_rx_dv` update on the clock edge that samples the second byte's stop bit. Both are therefore valid before the stop bit ends, about `CLKS_PER_BIT/2` cycles early.
- `o_rx_dv` is high for exactly one cycle per instruction. It is never asserted after the first byte, after a framing error, or after a false start.
- Mid-bit sampling tolerates ±~4% baud mismatch; for example, a 8600 ns bit against 217×40 ns = 8680 ns must decode correctly.
- Back-to-back bytes with a one-bit stop and zero idle gap must be received. CLEANUP plus the early stop sample leave enough margin for this.

## Test plan
- **Basic instruction:** reset; send 0x37 then 0xAB (25 MHz clock, 8600 ns bits, gaps arbitrary).
  - `o_rx_instr==16'hAB37` by the end of the second stop bit.
  - `o_rx_dv` pulses exactly once, for one cycle.
- **Byte ordering and hold:** send 0x00, 0xFF, then 0xFF, 0x00.
  - Results are `16'hFF00` then `16'h00FF`, with two `o_rx_dv` pulses.
  - `o_rx_instr` stays `16'hFF00` while the third byte is in flight.
- **False start:** a 2 µs low glitch on the line, then 0x12, 0x34.
  - Glitch ignored; result `16'h3412`, one pulse.
- **Framing error:** send 0x55 with stop bit 0, then 0x11, 0x22.
  - 0x55 discarded; result `16'h2211`; no pulse for the bad frame.
- **Reset mid-frame:** assert `rst` during bit 4 of the high byte (low byte 0x37 already received).
  - Outputs go to 0 immediately.
  - A following 0xCD, 0x01 yields `16'h01CD`.
- **Back-to-back words:** send four bytes with no idle gap (0x01 0x02 0x03 0x04).
  - Outputs `16'h0201` then `16'h0403`; two pulses, `CLKS_PER_BIT`×20 cycles apart.
